io_sequencer: RTL and testbench

Hardwired control sequencer for the datapath's instruction fetch and the port-I/O instructions `in`, `out`, `nop` and `halt`. It drives the datapath's per-cycle control strobes from a state register and waits on the input-port ready flag for `in`. It can abort a stalled `in` with a timeout and halt the CPU. The block sits between the IR/input port and the datapath control inputs.

---
 rtl/io_sequencer_if.sv | 62 ++++++
 rtl/io_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_io_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : io_sequencer_if
// Description : Bundle between the I/O sequencer and the datapath. It carries
//               the IR, the input-port ready flag, the run request, every
//               datapath control strobe and the sequencer status.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface io_sequencer_if;
  // Sequencer inputs
  logic [31:0] ir;
  logic        in_ready;
  logic        run;
  // Fetch-phase strobes
  logic        PCout;
  logic        MARin;
  logic        IncPC;
  logic        Zlowin;
  // Memory-read strobes
  logic        Zlowout;
  logic        PCin;
  logic        Read;
  logic        MD_read;
  logic        MDRin;
  // IR load strobes
  logic        MDRout;
  logic        IRin;
  // I/O transfer strobes
  logic        Gra;
  logic        Rin;
  logic        Rout;
  logic        InPortout;
  logic        Out_Portin;
  // Status
  logic        in_ack;
  logic        halted;
  logic        io_timeout;
  logic [3:0]  state;

  // Sequencer side
  modport master (
    input  ir, in_ready, run,
    output PCout, MARin, IncPC, Zlowin,
    output Zlowout, PCin, Read, MD_read, MDRin,
    output MDRout, IRin,
    output Gra, Rin, Rout, InPortout, Out_Portin,
    output in_ack, halted, io_timeout, state
  );

  // Datapath / port side
  modport slave (
    output ir, in_ready, run,
    input  PCout, MARin, IncPC, Zlowin,
    input  Zlowout, PCin, Read, MD_read, MDRin,
    input  MDRout, IRin,
    input  Gra, Rin, Rout, InPortout, Out_Portin,
    input  in_ack, halted, io_timeout, state
  );
endinterface

`default_nettype wire

// File: rtl/io_sequencer.sv
//------------------------------------------------------------------------------
// Module      : io_sequencer
// Description : Hardwired control sequencer for instruction fetch and the
//               port-I/O instructions in / out / nop / halt. Moore strobes are
//               registered from the next state, so they line up with the state
//               register. The optional IN_WAIT abort with timeout is enabled by
//               defining the macro IO_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input wire            clock,
  input wire            clear,
  io_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    T0       = 4'd1,
    T1       = 4'd2,
    T2       = 4'd3,
    T3       = 4'd4,
    IN_WAIT  = 4'd5,
    IN_XFER  = 4'd6,
    OUT_XFER = 4'd7,
    HALT     = 4'd8
  } state_t;

  localparam logic [4:0] c_op_in   = 5'b10110;
  localparam logic [4:0] c_op_out  = 5'b10111;
  localparam logic [4:0] c_op_halt = 5'b11011;

  // Bit positions inside the registered strobe vector
  localparam int c_b_pcout      = 17;
  localparam int c_b_marin      = 16;
  localparam int c_b_incpc      = 15;
  localparam int c_b_zlowin     = 14;
  localparam int c_b_zlowout    = 13;
  localparam int c_b_pcin       = 12;
  localparam int c_b_read       = 11;
  localparam int c_b_md_read    = 10;
  localparam int c_b_mdrin      = 9;
  localparam int c_b_mdrout     = 8;
  localparam int c_b_irin       = 7;
  localparam int c_b_gra        = 6;
  localparam int c_b_rin        = 5;
  localparam int c_b_rout       = 4;
  localparam int c_b_inportout  = 3;
  localparam int c_b_out_portin = 2;
  localparam int c_b_in_ack     = 1;
  localparam int c_b_halted     = 0;

  // A non-positive TIMEOUT_CYCLES is illegal; this empty scope marks such a
  // configuration in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
  end

  state_t      r_state;
  state_t      w_next_state;
  logic [17:0] r_strobes;
  logic [4:0]  w_opcode;

  assign w_opcode = bus.ir[31:27];

`ifdef IO_TIMEOUT_EN
  localparam int               c_cnt_w     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_io_timeout;
  logic               w_timeout_fire;
`endif

  // Moore strobe pattern for a given state; anything not listed stays low.
  function automatic logic [17:0] f_decode(input state_t s);
    logic [17:0] v;
    v = '0;
    case (s)
      T0: begin
        v[c_b_pcout]  = 1'b1;
        v[c_b_marin]  = 1'b1;
        v[c_b_incpc]  = 1'b1;
        v[c_b_zlowin] = 1'b1;
      end
      T1: begin
        v[c_b_zlowout] = 1'b1;
        v[c_b_pcin]    = 1'b1;
        v[c_b_read]    = 1'b1;
        v[c_b_md_read] = 1'b1;
        v[c_b_mdrin]   = 1'b1;
      end
      T2: begin
        v[c_b_mdrout] = 1'b1;
        v[c_b_irin]   = 1'b1;
      end
      IN_XFER: begin
        v[c_b_inportout] = 1'b1;
        v[c_b_gra]       = 1'b1;
        v[c_b_rin]       = 1'b1;
        v[c_b_in_ack]    = 1'b1;
      end
      OUT_XFER: begin
        v[c_b_gra]        = 1'b1;
        v[c_b_rout]       = 1'b1;
        v[c_b_out_portin] = 1'b1;
      end
      HALT: v[c_b_halted] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Next-state selection, including the optional IN_WAIT expiry.
  always_comb begin
    w_next_state = S_RESET;
`ifdef IO_TIMEOUT_EN
    w_timeout_fire = 1'b0;
`endif
    case (r_state)
      S_RESET:  w_next_state = T0;
      T0:       w_next_state = T1;
      T1:       w_next_state = T2;
      T2:       w_next_state = T3;
      T3: begin
        case (w_opcode)
          c_op_in:   w_next_state = IN_WAIT;
          c_op_out:  w_next_state = OUT_XFER;
          c_op_halt: w_next_state = HALT;
          default:   w_next_state = T0;
        endcase
      end
      IN_WAIT: begin
        if (bus.in_ready) begin
          // A ready flag in the expiry cycle still wins over the abort.
          w_next_state = IN_XFER;
        end else begin
          w_next_state = IN_WAIT;
`ifdef IO_TIMEOUT_EN
          if (r_wait_cnt == c_wait_last) begin
            w_next_state   = HALT;
            w_timeout_fire = 1'b1;
          end
`endif
        end
      end
      IN_XFER:  w_next_state = T0;
      OUT_XFER: w_next_state = T0;
      HALT:     w_next_state = bus.run ? T0 : HALT;
      default:  w_next_state = S_RESET;
    endcase
  end

  // State register, registered strobes, and the optional wait counter / flag.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_RESET;
      r_strobes <= '0;
`ifdef IO_TIMEOUT_EN
      r_wait_cnt   <= '0;
      r_io_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_next_state;
      r_strobes <= f_decode(w_next_state);
`ifdef IO_TIMEOUT_EN
      if (r_state != IN_WAIT) begin
        r_wait_cnt <= '0;
      end else if (!bus.in_ready) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
      end
      if (w_timeout_fire) begin
        r_io_timeout <= 1'b1;
      end else if ((r_state == HALT) && bus.run) begin
        r_io_timeout <= 1'b0;
      end
`endif
    end
  end

  assign bus.state      = r_state;
  assign bus.PCout      = r_strobes[c_b_pcout];
  assign bus.MARin      = r_strobes[c_b_marin];
  assign bus.IncPC      = r_strobes[c_b_incpc];
  assign bus.Zlowin     = r_strobes[c_b_zlowin];
  assign bus.Zlowout    = r_strobes[c_b_zlowout];
  assign bus.PCin       = r_strobes[c_b_pcin];
  assign bus.Read       = r_strobes[c_b_read];
  assign bus.MD_read    = r_strobes[c_b_md_read];
  assign bus.MDRin      = r_strobes[c_b_mdrin];
  assign bus.MDRout     = r_strobes[c_b_mdrout];
  assign bus.IRin       = r_strobes[c_b_irin];
  assign bus.Gra        = r_strobes[c_b_gra];
  assign bus.Rin        = r_strobes[c_b_rin];
  assign bus.Rout       = r_strobes[c_b_rout];
  assign bus.InPortout  = r_strobes[c_b_inportout];
  assign bus.Out_Portin = r_strobes[c_b_out_portin];
  assign bus.in_ack     = r_strobes[c_b_in_ack];
  assign bus.halted     = r_strobes[c_b_halted];

`ifdef IO_TIMEOUT_EN
  assign bus.io_timeout = r_io_timeout;
`else
  assign bus.io_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_io_sequencer
// Description : Directed self-checking bench for io_sequencer. Each cycle the
//               bench compares {state, all strobes, io_timeout} against a
//               hand-derived expected vector. Covers IO_TIMEOUT_EN when the
//               macro is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_sequencer;

  // Strobe order (MSB first): PCout MARin IncPC Zlowin | Zlowout PCin Read
  // MD_read MDRin | MDRout IRin | Gra Rin Rout InPortout Out_Portin |
  // in_ack halted io_timeout
  localparam logic [18:0] c_s_none = 19'd0;
  localparam logic [18:0] c_s_t0   = {4'b1111, 15'd0};
  localparam logic [18:0] c_s_t1   = {4'b0000, 5'b11111, 10'd0};
  localparam logic [18:0] c_s_t2   = {9'd0, 2'b11, 8'd0};
  localparam logic [18:0] c_s_in   = {11'd0, 5'b11010, 3'b100};
  localparam logic [18:0] c_s_out  = {11'd0, 5'b10101, 3'b000};
  localparam logic [18:0] c_s_halt = {17'd0, 2'b10};
  localparam logic [18:0] c_s_hto  = {17'd0, 2'b11};

  localparam logic [31:0] c_ir_in   = 32'hB080_0000;
  localparam logic [31:0] c_ir_out  = 32'hB880_0000;
  localparam logic [31:0] c_ir_nop  = 32'hD000_0000;
  localparam logic [31:0] c_ir_halt = 32'hD800_0000;
  localparam logic [31:0] c_ir_unk  = 32'h0000_0000;

  logic clock;
  logic clear;
  int   checks;
  int   failures;

  io_sequencer_if bus ();

  io_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  logic [22:0] w_obs;
  assign w_obs = {bus.state,
                  bus.PCout, bus.MARin, bus.IncPC, bus.Zlowin,
                  bus.Zlowout, bus.PCin, bus.Read, bus.MD_read, bus.MDRin,
                  bus.MDRout, bus.IRin,
                  bus.Gra, bus.Rin, bus.Rout, bus.InPortout, bus.Out_Portin,
                  bus.in_ack, bus.halted, bus.io_timeout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and settle just after the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] e [0:4];
    e = '{{4'd1, c_s_t0}, {4'd2, c_s_t1}, {4'd3, c_s_t2},
          {4'd4, c_s_none}, {4'd1, c_s_t0}};
    clear = 1'b1;
    bus.ir = c_ir_nop;
    bus.in_ready = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (w_obs !== 23'd0) begin
        failures++;
        $display("FAIL reset cycle=%0d got=%h exp=%h", i, w_obs, 23'd0);
      end
    end
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (w_obs !== e[i]) begin
        failures++;
        $display("FAIL fetch cycle=%0d got=%h exp=%h", i + 1, w_obs, e[i]);
      end
    end
  endtask

  // Enters at an observed T0 (cycle 1); opcode falls through back to T0.
  task automatic test_nop(input logic [31:0] ir_val, input string name);
    logic [22:0] e;
    bus.ir = ir_val;
    for (int c = 2; c <= 5; c++) begin
      step();
      case (c)
        2: e = {4'd2, c_s_t1};
        3: e = {4'd3, c_s_t2};
        4: e = {4'd4, c_s_none};
        default: e = {4'd1, c_s_t0};
      endcase
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", name, c, w_obs, e);
      end
    end
  endtask

  task automatic test_out();
    logic [22:0] e;
    bus.ir = c_ir_out;
    for (int c = 2; c <= 6; c++) begin
      step();
      case (c)
        2: e = {4'd2, c_s_t1};
        3: e = {4'd3, c_s_t2};
        4: e = {4'd4, c_s_none};
        5: e = {4'd7, c_s_out};
        default: e = {4'd1, c_s_t0};
      endcase
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL out cycle=%0d got=%h exp=%h", c, w_obs, e);
      end
    end
  endtask

  // `in` with `stall` IN_WAIT cycles of in_ready low before it rises.
  task automatic test_in(input int stall, input string name);
    logic [22:0] e;
    bus.ir = c_ir_in;
    bus.in_ready = (stall == 0);
    for (int c = 2; c <= 7 + stall; c++) begin
      step();
      if (c == 2)                 e = {4'd2, c_s_t1};
      else if (c == 3)            e = {4'd3, c_s_t2};
      else if (c == 4)            e = {4'd4, c_s_none};
      else if (c <= 5 + stall)    e = {4'd5, c_s_none};
      else if (c == 6 + stall)    e = {4'd6, c_s_in};
      else                        e = {4'd1, c_s_t0};
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", name, c, w_obs, e);
      end
      bus.in_ready = (c == 5 + stall) || ((stall == 0) && (c < 5));
    end
  endtask

  task automatic test_halt();
    logic [22:0] e;
    bus.ir = c_ir_halt;
    bus.in_ready = 1'b0;
    for (int c = 2; c <= 25; c++) begin
      step();
      if (c == 2)       e = {4'd2, c_s_t1};
      else if (c == 3)  e = {4'd3, c_s_t2};
      else if (c == 4)  e = {4'd4, c_s_none};
      else if (c <= 24) e = {4'd8, c_s_halt};
      else              e = {4'd1, c_s_t0};
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL halt cycle=%0d got=%h exp=%h", c, w_obs, e);
      end
      bus.in_ready = (c >= 5) && (c <= 24) && (c % 2 == 1);
      bus.run = (c == 24);
    end
    bus.run = 1'b0;
    bus.in_ready = 1'b0;
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    logic [22:0] e;
    bus.ir = c_ir_in;
    bus.in_ready = 1'b0;
    for (int c = 2; c <= 262; c++) begin
      step();
      if (c == 2)        e = {4'd2, c_s_t1};
      else if (c == 3)   e = {4'd3, c_s_t2};
      else if (c == 4)   e = {4'd4, c_s_none};
      else if (c <= 259) e = {4'd5, c_s_none};
      else if (c <= 261) e = {4'd8, c_s_hto};
      else               e = {4'd1, c_s_t0};
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL timeout cycle=%0d got=%h exp=%h", c, w_obs, e);
      end
      bus.run = (c == 261);
    end
    bus.run = 1'b0;
  endtask
`endif

  task automatic test_clear_mid();
    logic [22:0] e;
    bus.ir = c_ir_in;
    bus.in_ready = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      step();
      if (c == 2)      e = {4'd2, c_s_t1};
      else if (c == 3) e = {4'd3, c_s_t2};
      else if (c == 4) e = {4'd4, c_s_none};
      else if (c <= 6) e = {4'd5, c_s_none};
      else if (c == 7) e = 23'd0;
      else             e = {4'd1, c_s_t0};
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL clear_mid cycle=%0d got=%h exp=%h", c, w_obs, e);
      end
      clear = (c == 6);
      bus.in_ready = (c == 6);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear = 1'b1;
    bus.ir = 32'd0;
    bus.in_ready = 1'b0;
    bus.run = 1'b0;
    test_reset();
    test_nop(c_ir_nop, "nop");
    test_nop(c_ir_unk, "unknown_op");
    test_in(0, "in_ready");
    test_in(10, "in_stall");
    test_out();
    test_in(254, "in_expiry_ready");
    test_halt();
`ifdef IO_TIMEOUT_EN
    test_timeout();
`else
    test_in(300, "in_no_timeout");
`endif
    test_clear_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
